// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: read-after-write hazard tracking for the execute stage.
// One small counter per architectural register records writes that have been
// issued into execute but not yet retired at writeback. The instruction in
// execute is held while any register it reads, or a register it writes whose
// counter is already full, has an unretired write.
module hazard_scoreboard #(
    parameter int unsigned REGNO     = 8,
    parameter int unsigned REGNO_LOG = 3,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned PERF_W    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [REGNO_LOG-1:0] i_l_sel,
    input  logic [REGNO_LOG-1:0] i_r_sel,
    input  logic                 i_l_use,
    input  logic                 i_r_use,
    input  logic [REGNO-1:0]     i_rf_ie,
    input  logic                 i_next_ready,
    output logic                 o_stall,
    output logic                 o_issue,
    input  logic [REGNO-1:0]     i_wb_ie,
    input  logic                 i_wb_valid,
    output logic [REGNO-1:0]     o_pending,
    output logic                 o_busy,
    output logic                 o_err,
    output logic [PERF_W-1:0]    o_stall_cnt
);

    logic [REGNO-1:0][CNT_W-1:0] cnt_q;
    logic [REGNO-1:0][CNT_W-1:0] cnt_d;
    logic                        err_q;
    logic                        err_d;
    logic [PERF_W-1:0]           stall_cnt_q;
    logic [PERF_W-1:0]           stall_cnt_d;

    logic [REGNO-1:0]            pending;
    logic [REGNO-1:0]            full;
    logic [REGNO-1:0]            inc_mask;
    logic [REGNO-1:0]            dec_mask;
    logic [REGNO-1:0]            underflow;
    logic                        src_hz;
    logic                        sat_hz;
    logic                        stall;
    logic                        issue;

    // Hazard detection from the registered counters only; a retire in this
    // same cycle is not visible until the counter updates at the edge.
    always_comb begin
        pending = '0;
        full    = '0;
        for (int unsigned k = 0; k < REGNO; k++) begin
            pending[k] = (cnt_q[k] != '0);
            full[k]    = (cnt_q[k] == '1);
        end
        src_hz    = (i_l_use & pending[i_l_sel]) | (i_r_use & pending[i_r_sel]);
        sat_hz    = |(i_rf_ie & full);
        stall     = i_valid & (src_hz | sat_hz);
        issue     = i_valid & i_next_ready & ~stall;
        inc_mask  = {REGNO{issue}} & i_rf_ie;
        dec_mask  = {REGNO{i_wb_valid}} & i_wb_ie;
        underflow = dec_mask & ~pending;
    end

    // Per-register counter update, sticky underflow flag and stall counter.
    // A retire against an empty counter is dropped (and flagged) rather than
    // cancelling a same-cycle issue, so the newly issued write stays tracked.
    always_comb begin
        cnt_d       = cnt_q;
        err_d       = err_q | (|underflow);
        stall_cnt_d = stall_cnt_q;
        for (int unsigned k = 0; k < REGNO; k++) begin
            case ({inc_mask[k], dec_mask[k] & pending[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + CNT_W'(1);
                2'b01:   cnt_d[k] = cnt_q[k] - CNT_W'(1);
                default: cnt_d[k] = cnt_q[k];
            endcase
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q       <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Output drive.
    always_comb begin
        o_stall     = stall;
        o_issue     = issue;
        o_pending   = pending;
        o_busy      = |pending;
        o_err       = err_q;
        o_stall_cnt = stall_cnt_q;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic checked
// against an integer per-register outstanding-write model.
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic [2:0] l_sel;
    logic [2:0] r_sel;
    logic       l_use;
    logic       r_use;
    logic [7:0] rf_ie;
    logic       next_ready;
    logic       stall;
    logic       issue;
    logic [7:0] wb_ie;
    logic       wb_valid;
    logic [7:0] pending;
    logic       busy;
    logic       err;
    logic [15:0] stall_cnt;

    int total;
    int bad;

    // reference model
    int m_cnt [8];
    bit m_err;
    int m_scnt;

    hazard_scoreboard #(
        .REGNO    (8),
        .REGNO_LOG(3),
        .CNT_W    (2),
        .PERF_W   (16)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (valid),
        .i_l_sel     (l_sel),
        .i_r_sel     (r_sel),
        .i_l_use     (l_use),
        .i_r_use     (r_use),
        .i_rf_ie     (rf_ie),
        .i_next_ready(next_ready),
        .o_stall     (stall),
        .o_issue     (issue),
        .i_wb_ie     (wb_ie),
        .i_wb_valid  (wb_valid),
        .o_pending   (pending),
        .o_busy      (busy),
        .o_err       (err),
        .o_stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic bit model_stall();
        bit hz;
        hz = (l_use && m_cnt[l_sel] > 0) || (r_use && m_cnt[r_sel] > 0);
        for (int k = 0; k < 8; k++) if (rf_ie[k] && m_cnt[k] == 3) hz = 1;
        return valid && hz;
    endfunction

    function automatic bit model_issue();
        return valid && next_ready && !model_stall();
    endfunction

    function automatic logic [7:0] model_pending();
        logic [7:0] p;
        for (int k = 0; k < 8; k++) p[k] = (m_cnt[k] != 0);
        return p;
    endfunction

    task automatic idle();
        valid = 0; l_sel = 0; r_sel = 0; l_use = 0; r_use = 0;
        rf_ie = 0; next_ready = 1; wb_ie = 0; wb_valid = 0;
    endtask

    // clock one edge and advance the model with the inputs seen at that edge
    task automatic cycle();
        bit st, is;
        @(posedge clk);
        st = model_stall();
        is = model_issue();
        if (st && m_scnt < 65535) m_scnt++;
        for (int k = 0; k < 8; k++) begin
            int inc, dec;
            inc = (is && rf_ie[k]) ? 1 : 0;
            dec = (wb_valid && wb_ie[k]) ? 1 : 0;
            if (dec == 1 && m_cnt[k] == 0) begin
                m_err = 1;
                dec = 0;
            end
            m_cnt[k] = m_cnt[k] + inc - dec;
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        #2;
        for (int k = 0; k < 8; k++) m_cnt[k] = 0;
        m_err = 0;
        m_scnt = 0;
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #2;
        for (int k = 0; k < 8; k++) m_cnt[k] = 0;
        m_err = 0;
        m_scnt = 0;
        total++;
        if (pending !== 8'h00 || busy !== 1'b0 || err !== 1'b0 || stall_cnt !== 16'd0 || stall !== 1'b0) begin
            $display("FAIL reset_state: pending=%h busy=%b err=%b cnt=%0d stall=%b expected 00/0/0/0/0",
                     pending, busy, err, stall_cnt, stall);
            bad++;
        end
        rst_n = 1;
        #1;
        cycle();
        total++;
        if (pending !== 8'h00 || stall_cnt !== 16'd0) begin
            $display("FAIL reset_after_release: pending=%h cnt=%0d expected 00/0", pending, stall_cnt);
            bad++;
        end
    endtask

    task automatic test_back_to_back_raw();
        do_reset();
        valid = 1; rf_ie = 8'h08;
        #1;
        total++;
        if (issue !== 1'b1) begin
            $display("FAIL raw_first_issue: issue=%b expected 1", issue); bad++;
        end
        cycle();
        total++;
        if (pending !== 8'h08) begin
            $display("FAIL raw_pending: pending=%h expected 08", pending); bad++;
        end
        rf_ie = 0; l_sel = 3; l_use = 1;
        #1;
        total++;
        if (stall !== 1'b1 || issue !== 1'b0) begin
            $display("FAIL raw_stall: stall=%b issue=%b expected 1/0", stall, issue); bad++;
        end
        cycle();
        wb_valid = 1; wb_ie = 8'h08;
        #1;
        total++;
        if (stall !== 1'b1) begin
            $display("FAIL raw_retire_same_cycle: stall=%b expected 1", stall); bad++;
        end
        cycle();
        wb_valid = 0; wb_ie = 0;
        #1;
        total++;
        if (stall !== 1'b0 || issue !== 1'b1 || pending !== 8'h00) begin
            $display("FAIL raw_release: stall=%b issue=%b pending=%h expected 0/1/00", stall, issue, pending); bad++;
        end
        total++;
        if (stall_cnt !== 16'd2 || stall_cnt !== 16'(m_scnt)) begin
            $display("FAIL raw_stall_cnt: cnt=%0d expected 2 (model %0d)", stall_cnt, m_scnt); bad++;
        end
        cycle();
        idle();
    endtask

    task automatic test_immediate();
        do_reset();
        valid = 1; rf_ie = 8'h04;
        cycle();
        rf_ie = 0; r_sel = 2; l_sel = 2; r_use = 0; l_use = 0;
        #1;
        total++;
        if (stall !== 1'b0 || issue !== 1'b1) begin
            $display("FAIL immediate: stall=%b issue=%b expected 0/1", stall, issue); bad++;
        end
        cycle();
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        valid = 1; rf_ie = 8'h02;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (issue !== 1'b1) begin
                $display("FAIL sat_fill_%0d: issue=%b expected 1", i, issue); bad++;
            end
            cycle();
        end
        #1;
        total++;
        if (stall !== 1'b1 || issue !== 1'b0) begin
            $display("FAIL sat_stall: stall=%b issue=%b expected 1/0", stall, issue); bad++;
        end
        cycle();
        wb_valid = 1; wb_ie = 8'h02;
        #1;
        total++;
        if (stall !== 1'b1) begin
            $display("FAIL sat_retire_same_cycle: stall=%b expected 1", stall); bad++;
        end
        cycle();
        wb_valid = 0; wb_ie = 0;
        #1;
        total++;
        if (stall !== 1'b0 || issue !== 1'b1) begin
            $display("FAIL sat_release: stall=%b issue=%b expected 0/1", stall, issue); bad++;
        end
        cycle();
        #1;
        total++;
        if (stall !== 1'b1) begin
            $display("FAIL sat_back_to_full: stall=%b expected 1", stall); bad++;
        end
        valid = 0; rf_ie = 0;
        wb_valid = 1; wb_ie = 8'h02;
        cycle(); cycle();
        total++;
        if (pending !== 8'h02) begin
            $display("FAIL sat_drain_two: pending=%h expected 02", pending); bad++;
        end
        cycle();
        total++;
        if (pending !== 8'h00 || err !== 1'b0) begin
            $display("FAIL sat_drain_all: pending=%h err=%b expected 00/0", pending, err); bad++;
        end
        idle();
    endtask

    task automatic test_same_cycle();
        do_reset();
        valid = 1; rf_ie = 8'h20;
        cycle();
        wb_valid = 1; wb_ie = 8'h20;
        #1;
        total++;
        if (issue !== 1'b1) begin
            $display("FAIL same_cycle_issue: issue=%b expected 1", issue); bad++;
        end
        cycle();
        idle();
        #1;
        total++;
        if (pending !== 8'h20) begin
            $display("FAIL same_cycle_pending: pending=%h expected 20", pending); bad++;
        end
        wb_valid = 1; wb_ie = 8'h20;
        cycle();
        idle();
        total++;
        if (pending !== 8'h00 || err !== 1'b0) begin
            $display("FAIL same_cycle_count_one: pending=%h err=%b expected 00/0", pending, err); bad++;
        end
    endtask

    task automatic test_underflow_async_reset();
        do_reset();
        valid = 1; rf_ie = 8'h01;
        cycle();
        rf_ie = 0; r_sel = 0; r_use = 1;
        cycle();
        valid = 0; r_use = 0;
        wb_valid = 1; wb_ie = 8'h81;
        cycle();
        idle();
        total++;
        if (err !== 1'b1 || pending !== 8'h00) begin
            $display("FAIL underflow_flag: err=%b pending=%h expected 1/00", err, pending); bad++;
        end
        cycle(); cycle();
        total++;
        if (err !== 1'b1 || stall_cnt !== 16'd1) begin
            $display("FAIL underflow_sticky: err=%b cnt=%0d expected 1/1", err, stall_cnt); bad++;
        end
        valid = 1; rf_ie = 8'h10;
        cycle();
        #2;
        rst_n = 0;
        #1;
        for (int k = 0; k < 8; k++) m_cnt[k] = 0;
        m_err = 0;
        m_scnt = 0;
        total++;
        if (err !== 1'b0 || pending !== 8'h00 || busy !== 1'b0 || stall_cnt !== 16'd0) begin
            $display("FAIL async_reset: err=%b pending=%h busy=%b cnt=%0d expected 0/00/0/0",
                     err, pending, busy, stall_cnt); bad++;
        end
        idle();
        #1;
        rst_n = 1;
        cycle();
    endtask

    task automatic test_backpressure();
        do_reset();
        valid = 1; next_ready = 0; rf_ie = 8'h04; l_sel = 6; l_use = 1;
        #1;
        total++;
        if (issue !== 1'b0 || stall !== 1'b0) begin
            $display("FAIL backpressure_comb: issue=%b stall=%b expected 0/0", issue, stall); bad++;
        end
        cycle(); cycle();
        total++;
        if (pending !== 8'h00 || stall_cnt !== 16'd0) begin
            $display("FAIL backpressure_state: pending=%h cnt=%0d expected 00/0", pending, stall_cnt); bad++;
        end
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] w;
            valid      = ($urandom_range(3) != 0);
            l_sel      = 3'($urandom_range(7));
            r_sel      = 3'($urandom_range(7));
            l_use      = ($urandom_range(1) == 1);
            r_use      = ($urandom_range(2) != 0);
            next_ready = ($urandom_range(4) != 0);
            case ($urandom_range(5))
                0:       rf_ie = 8'h00;
                1:       rf_ie = 8'h01 << $urandom_range(7) | 8'h01 << $urandom_range(7);
                default: rf_ie = 8'h01 << $urandom_range(7);
            endcase
            w = 0;
            for (int k = 0; k < 8; k++) w[k] = (m_cnt[k] > 0) && ($urandom_range(2) == 0);
            wb_ie    = w;
            wb_valid = ($urandom_range(4) != 0);
            if (!wb_valid && $urandom_range(1) == 1) wb_ie = 8'($urandom);
            #1;
            total++;
            if (stall !== model_stall() || issue !== model_issue()) begin
                $display("FAIL rand_comb[%0d]: stall=%b issue=%b expected %b/%b",
                         n, stall, issue, model_stall(), model_issue()); bad++;
            end
            total++;
            if (pending !== model_pending() || busy !== (model_pending() != 0) ||
                err !== m_err || stall_cnt !== 16'(m_scnt)) begin
                $display("FAIL rand_state[%0d]: pending=%h busy=%b err=%b cnt=%0d expected %h/%b/%b/%0d",
                         n, pending, busy, err, stall_cnt, model_pending(),
                         model_pending() != 0, m_err, m_scnt); bad++;
            end
            cycle();
        end
        idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1;
        idle();
        #3;
        test_reset();
        test_back_to_back_raw();
        test_immediate();
        test_saturation();
        test_same_cycle();
        test_underflow_async_reset();
        test_backpressure();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
